// File: rtl/debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : debounce_pkg                                               |
// | Default parameters and stable-level type for the debouncer slice.    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package debounce_pkg;

    localparam int DB_N_CH          = 4;
    localparam int DB_CNT_W         = 16;
    localparam int DB_STABLE_CYCLES = 65535;
    localparam int DB_HOLD_CYCLES   = 50000000;

    typedef enum logic {
        DB_LOW  = 1'b0,
        DB_HIGH = 1'b1
    } db_level_e;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : debounce_multi_if                                        |
// | Raw button inputs and debounced level/pulse outputs, N_CH wide.      |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
interface debounce_multi_if
    import debounce_pkg::*;
#(
    parameter int N_CH = DB_N_CH
);
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] db_out;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
    logic [N_CH-1:0] hold_pulse;

    modport master (
        output btn,
        input  db_out,
        input  rise_pulse,
        input  fall_pulse,
        input  hold_pulse
    );

    modport slave (
        input  btn,
        output db_out,
        output rise_pulse,
        output fall_pulse,
        output hold_pulse
    );
endinterface : debounce_multi_if
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : debounce_ch                                                 |
// | One channel: 2-FF sync, stability filter, edge pulses, optional      |
// | hold pulse (enabled by macro DEBOUNCE_HOLD_EN).                      |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int CNT_W         = DB_CNT_W,
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES
`ifdef DEBOUNCE_HOLD_EN
    ,
    parameter int HOLD_CYCLES   = DB_HOLD_CYCLES
`endif
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_btn,
    output logic      o_db,
    output logic      o_rise,
    output logic      o_fall,
    output logic      o_hold
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    db_level_e        r_level;
    db_level_e        w_level;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic             r_rise;
    logic             r_fall;
    logic             w_rise;
    logic             w_fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_level <= DB_LOW;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync0 <= i_btn;
            r_sync1 <= r_sync0;
            r_level <= w_level;
            r_cnt   <= w_cnt;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
        end
    end

    // Any cycle where the synced input matches the stable level restarts the count.
    always_comb begin
        w_level = r_level;
        w_cnt   = '0;
        w_rise  = 1'b0;
        w_fall  = 1'b0;
        case (r_level)
            DB_LOW: begin
                if (r_sync1) begin
                    if (r_cnt == C_CNT_LAST) begin
                        w_level = DB_HIGH;
                        w_rise  = 1'b1;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            DB_HIGH: begin
                if (!r_sync1) begin
                    if (r_cnt == C_CNT_LAST) begin
                        w_level = DB_LOW;
                        w_fall  = 1'b1;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_level = DB_LOW;
        endcase
    end

    assign o_db   = (r_level == DB_HIGH);
    assign o_rise = r_rise;
    assign o_fall = r_fall;

`ifdef DEBOUNCE_HOLD_EN
    localparam int                  C_HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_MAX = C_HOLD_W'(HOLD_CYCLES);

    logic [C_HOLD_W-1:0] r_hold_cnt;
    logic                r_hold;

    // Counter saturates at HOLD_CYCLES so a long press yields a single pulse.
    always_ff @(posedge clk) begin
        if (!rst_n || r_level == DB_LOW) begin
            r_hold_cnt <= '0;
            r_hold     <= 1'b0;
        end else if (r_hold_cnt != C_HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + C_HOLD_W'(1);
            r_hold     <= (r_hold_cnt == C_HOLD_MAX - C_HOLD_W'(1));
        end else begin
            r_hold     <= 1'b0;
        end
    end

    assign o_hold = r_hold;
`else
    assign o_hold = 1'b0;
`endif

endmodule : debounce_ch
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : debounce_multi                                              |
// | N_CH independent debounce channels with rise/fall/hold pulses.       |
// | Optional hold-pulse feature: define macro DEBOUNCE_HOLD_EN.          |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH          = DB_N_CH,
    parameter int CNT_W         = DB_CNT_W,
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DB_HOLD_CYCLES
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    debounce_multi_if.slave bus
);

    if (N_CH < 1) begin : g_chk_nch
        $error("debounce_multi: N_CH must be >= 1");
    end

    if (STABLE_CYCLES < 1 || 64'(STABLE_CYCLES) >= (64'd1 << CNT_W)) begin : g_chk_stable
        $error("debounce_multi: STABLE_CYCLES must be in 1..2**CNT_W-1");
    end

    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("debounce_multi: HOLD_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .CNT_W         (CNT_W),
            .STABLE_CYCLES (STABLE_CYCLES)
`ifdef DEBOUNCE_HOLD_EN
            ,
            .HOLD_CYCLES   (HOLD_CYCLES)
`endif
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_btn  (bus.btn[i]),
            .o_db   (bus.db_out[i]),
            .o_rise (bus.rise_pulse[i]),
            .o_fall (bus.fall_pulse[i]),
            .o_hold (bus.hold_pulse[i])
        );
    end

endmodule : debounce_multi
`default_nettype wire
